systolic_drain: RTL and testbench

Result drain for the systolic MAC array: the reader side of the per-PE accumulator outputs. On a tile-done pulse it snapshots every PE accumulator in one cycle, rescales and saturates each value to the output width, and streams the tile out one row per beat over a valid/ready interface. This frees the array to clear and start the next tile while results drain. It sits between the PE grid and the output write-back path.

---
 rtl/systolic_drain.sv | 117 +++++++++++
 tb/tb_systolic_drain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - snapshots PE accumulators on tile_done, rescales/saturates, streams one row per beat
module systolic_drain #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int AW    = 48,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*COLS*AW-1:0]  acc_in,
  input  logic                     tile_done,
  output logic [COLS*OW-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_row,
  output logic                     out_last,
  output logic                     out_sat,
  output logic                     busy,
  output logic                     tile_out_done,
  output logic                     overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam int          RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW:0] RND  = (SHIFT > 0) ? ((AW+1)'(1) << RSH) : '0;
  localparam logic [AW:0] MAXV = ((AW+1)'(1) << (OW - 1)) - (AW+1)'(1);
  localparam logic [AW:0] MINV = ~MAXV;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t r_state, w_state_nxt;

  logic [ROWS-1:0][COLS*OW-1:0] r_snap_data, w_snap_data;
  logic [ROWS-1:0]              r_snap_sat,  w_snap_sat;
  logic [RW-1:0]                r_row;
  logic                         r_tod;
  logic                         r_overrun;

  logic w_valid, w_xfer, w_last_xfer, w_capture, w_drop;

  // Returns {sat, value}; the extra headroom bit keeps the rounding add from wrapping.
  function automatic logic [OW:0] conv(input logic [AW-1:0] a);
    logic signed [AW:0] t;
    logic signed [AW:0] s;
    t = $signed({a[AW-1], a}) + $signed(RND);
    s = t >>> SHIFT;
    if (s > $signed(MAXV))      conv = {1'b1, MAXV[OW-1:0]};
    else if (s < $signed(MINV)) conv = {1'b1, MINV[OW-1:0]};
    else                        conv = {1'b0, s[OW-1:0]};
  endfunction

  always_comb begin
    logic [OW:0] w_e;
    w_snap_data = '0;
    w_snap_sat  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_e = conv(acc_in[(r*COLS+c)*AW +: AW]);
        w_snap_data[r][c*OW +: OW] = w_e[OW-1:0];
        w_snap_sat[r] = w_snap_sat[r] | w_e[OW];
      end
    end
  end

  assign w_valid     = (r_state == STREAM);
  assign w_xfer      = w_valid && out_ready;
  assign w_last_xfer = w_xfer && (r_row == LAST_ROW);
  // A new tile is accepted only when the holding buffer is free or freeing this very cycle.
  assign w_capture   = tile_done && (!w_valid || w_last_xfer);
  assign w_drop      = tile_done && w_valid && !w_last_xfer;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (tile_done) w_state_nxt = STREAM;
      STREAM:  if (w_last_xfer && !tile_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_data <= '0;
      r_snap_sat  <= '0;
      r_row       <= '0;
      r_tod       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tod <= w_last_xfer;
      if (w_drop) r_overrun <= 1'b1;
      if (w_capture) begin
        r_snap_data <= w_snap_data;
        r_snap_sat  <= w_snap_sat;
        r_row       <= '0;
      end else if (w_xfer) begin
        r_row <= w_last_xfer ? '0 : r_row + RW'(1);
      end
    end
  end

  assign out_valid     = w_valid;
  assign busy          = w_valid;
  assign out_row       = r_row;
  assign out_data      = w_valid ? r_snap_data[r_row] : '0;
  assign out_sat       = w_valid && r_snap_sat[r_row];
  assign out_last      = w_valid && (r_row == LAST_ROW);
  assign tile_out_done = r_tod;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - directed and randomized checks of systolic_drain against a behavioural model
module tb_systolic_drain;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int AW = 48;
  localparam int OW = 16;
  localparam int SH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [R*C*AW-1:0] acc_in;
  logic              tile_done;
  logic [C*OW-1:0]   out_data;
  logic              out_valid;
  logic              out_ready;
  logic [0:0]        out_row;
  logic              out_last;
  logic              out_sat;
  logic              busy;
  logic              tile_out_done;
  logic              overrun;

  int n_tests = 0;
  int n_fail  = 0;

  longint acc_m [R][C];
  longint exp_v [R][C];
  bit     exp_s [R];

  systolic_drain #(.ROWS(R), .COLS(C), .AW(AW), .OW(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .tile_done(tile_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last), .out_sat(out_sat), .busy(busy),
    .tile_out_done(tile_out_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Round-half-up, floor shift, clamp to signed OW range.
  function automatic longint conv(input longint a, output bit s);
    longint t, maxv, minv;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -maxv - 1;
    t = a;
    if (SH > 0) t = t + (longint'(1) <<< (SH - 1));
    t = t >>> SH;
    s = 1'b0;
    if (t > maxv) begin t = maxv; s = 1'b1; end
    else if (t < minv) begin t = minv; s = 1'b1; end
    return t;
  endfunction

  function automatic longint rand_acc();
    case ($urandom_range(0, 3))
      0:       return longint'(int'($urandom_range(0, 1200000))) - 600000;
      1:       return longint'(int'($urandom));
      2:       return longint'(int'($urandom)) <<< 16;
      default: return longint'(int'($urandom_range(0, 40))) - 20;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_acc();
    bit s;
    for (int r = 0; r < R; r++) begin
      exp_s[r] = 1'b0;
      for (int c = 0; c < C; c++) begin
        acc_in[(r*C+c)*AW +: AW] = acc_m[r][c][AW-1:0];
        exp_v[r][c] = conv(acc_m[r][c], s);
        exp_s[r] = exp_s[r] | s;
      end
    end
  endtask

  task automatic rand_tile();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        acc_m[r][c] = rand_acc();
    set_acc();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int r);
    logic [C*OW-1:0] e;
    for (int c = 0; c < C; c++) e[c*OW +: OW] = OW'(exp_v[r][c]);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_busy"},  64'(busy), 64'(1));
    chk({tag, "_row"},   64'(out_row), 64'(r));
    chk({tag, "_last"},  64'(out_last), 64'(r == R - 1));
    chk({tag, "_sat"},   64'(out_sat), 64'(exp_s[r]));
    chk({tag, "_data"},  64'(out_data), 64'(e));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
  endtask

  initial begin
    logic [C*OW-1:0] held;
    int  row, cyc;
    bit  xfer, done_seen;

    rst = 1'b1; tile_done = 1'b0; out_ready = 1'b0; acc_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_data",  64'(out_data), 64'(0));
    chk("rst_row",   64'(out_row), 64'(0));
    chk("rst_last",  64'(out_last), 64'(0));
    chk("rst_sat",   64'(out_sat), 64'(0));
    chk("rst_tod",   64'(tile_out_done), 64'(0));
    chk("rst_ovr",   64'(overrun), 64'(0));

    // Basic conversion
    acc_m = '{'{160, -32}, '{17, 8}};
    set_acc();
    tile_done = 1'b1; out_ready = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("basic_b0_lit", 64'(out_data), 64'({16'hFFFE, 16'd10}));
    check_beat("basic_b0", 0);
    tick();
    chk("basic_b1_lit", 64'(out_data), 64'({16'd1, 16'd1}));
    check_beat("basic_b1", 1);
    chk("basic_b1_tod", 64'(tile_out_done), 64'(0));
    tick();
    chk("basic_tod", 64'(tile_out_done), 64'(1));
    check_idle("basic_end");
    tick();
    chk("basic_tod_pulse", 64'(tile_out_done), 64'(0));

    // Saturation
    acc_m = '{'{1048576, -1048576}, '{0, 0}};
    set_acc();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("sat_b0_lit", 64'(out_data), 64'({16'h8000, 16'h7FFF}));
    chk("sat_b0_flag", 64'(out_sat), 64'(1));
    check_beat("sat_b0", 0);
    tick();
    chk("sat_b1_lit", 64'(out_data), 64'(0));
    check_beat("sat_b1", 1);
    tick();
    chk("sat_tod", 64'(tile_out_done), 64'(1));

    // Backpressure
    rand_tile();
    tile_done = 1'b1; out_ready = 1'b0;
    tick();
    tile_done = 1'b0;
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      check_beat("bp_hold", 0);
      chk("bp_stable", 64'(out_data), 64'(held));
      tick();
    end
    out_ready = 1'b1;
    check_beat("bp_b0", 0);
    tick();
    check_beat("bp_b1", 1);
    tick();
    chk("bp_tod", 64'(tile_out_done), 64'(1));
    check_idle("bp_end");

    // Back-to-back: new tile_done on the last-beat transfer
    rand_tile();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    check_beat("b2b_a0", 0);
    tick();
    check_beat("b2b_a1", 1);
    acc_m = '{'{16, 16}, '{16, 16}};
    set_acc();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("b2b_lit", 64'(out_data), 64'({16'd1, 16'd1}));
    check_beat("b2b_b0", 0);
    chk("b2b_tod", 64'(tile_out_done), 64'(1));
    chk("b2b_ovr", 64'(overrun), 64'(0));
    tick();
    check_beat("b2b_b1", 1);
    tick();
    chk("b2b_tod2", 64'(tile_out_done), 64'(1));

    // Overrun while beat 0 stalls
    rand_tile();
    tile_done = 1'b1; out_ready = 1'b0;
    tick();
    acc_in = ~acc_in;
    tick();
    tile_done = 1'b0;
    chk("ovr_set", 64'(overrun), 64'(1));
    check_beat("ovr_b0", 0);
    out_ready = 1'b1;
    tick();
    check_beat("ovr_b1", 1);
    tick();
    chk("ovr_tod", 64'(tile_out_done), 64'(1));
    chk("ovr_sticky", 64'(overrun), 64'(1));

    // Randomized tiles with random backpressure
    for (int t = 0; t < 30; t++) begin
      rand_tile();
      tile_done = 1'b1;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      tile_done = 1'b0;
      row = 0; cyc = 0; done_seen = 1'b0;
      while (!done_seen && cyc < 100) begin
        check_beat("rnd", row);
        xfer = out_ready;
        tick();
        if (xfer) begin
          if (row == R - 1) begin
            chk("rnd_tod", 64'(tile_out_done), 64'(1));
            check_idle("rnd_end");
            done_seen = 1'b1;
          end else begin
            row++;
          end
        end
        out_ready = ($urandom_range(0, 9) < 7);
        cyc++;
      end
      if (!done_seen) chk("rnd_timeout", 64'(0), 64'(1));
    end
    chk("rnd_ovr_sticky", 64'(overrun), 64'(1));

    // Reset mid-stream
    rand_tile();
    tile_done = 1'b1; out_ready = 1'b1;
    tick();
    tile_done = 1'b0;
    tick();
    check_beat("mid_b1", 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 64'(out_valid), 64'(0));
    chk("mid_busy",  64'(busy), 64'(0));
    chk("mid_ovr",   64'(overrun), 64'(0));
    chk("mid_row",   64'(out_row), 64'(0));
    chk("mid_tod",   64'(tile_out_done), 64'(0));

    // rst wins over tile_done in IDLE
    rand_tile();
    rst = 1'b1; tile_done = 1'b1;
    tick();
    rst = 1'b0; tile_done = 1'b0;
    check_idle("rstwin");

    // Fresh tile after reset
    rand_tile();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    check_beat("fresh_b0", 0);
    tick();
    check_beat("fresh_b1", 1);
    tick();
    chk("fresh_tod", 64'(tile_out_done), 64'(1));
    chk("fresh_ovr", 64'(overrun), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
